bullet_engine: RTL and testbench
================================

BULLET_ENGINE -- requirements
Module: bullet_engine

Interface
REQ-001 Parameter N_SLOTS, default 4, number of simultaneously live bullets (1..16).
REQ-002 Parameter SIZE, default 6, bullet sprite edge in pixels (2..15).
REQ-003 Parameter R2, default 26, disk threshold in doubled-coordinate units (see REQ-016).
REQ-004 Parameter SPEED, default 4, pixels moved per frame_tick (1..31).
REQ-005 Parameter XW/YW, default 10/10, coordinate widths.
REQ-006 Port clk  in  1  single system clock, rising edge.
REQ-007 Port rst_n  in  1  asynchronous, active-low reset.
REQ-008 Port fire  in  1  spawn request, sampled each clk.
REQ-009 Port fire_x/fire_y  in  XW/YW  top-left spawn position.
REQ-010 Port frame_tick  in  1  one-cycle pulse per video frame.
REQ-011 Port kill_valid / kill_id  in  1 / clog2(N_SLOTS)  free one slot (external collision logic).
REQ-012 Port pix_x/pix_y  in  XW/YW  current raster pixel.
REQ-013 Port fire_ack / fire_drop  out  1 / 1  one-cycle result pulses for a fire request.
REQ-014 Port active  out  N_SLOTS  per-slot live flags; pixel_on out 1; pixel_id out clog2(N_SLOTS).

Function
REQ-015 Each slot SHALL be a two-state FSM, FREE/LIVE, holding bx[XW], by[YW].
REQ-016 Sprite mask bit (dx,dy), 0<=dx,dy<SIZE, SHALL be 1 iff (2dx-SIZE+1)^2+(2dy-SIZE+1)^2 <= R2; defaults yield rows 001100/011110/111111/111111/011110/001100.
REQ-017 On fire=1, the lowest-index slot FREE at cycle start SHALL go LIVE next edge with bx=fire_x, by=fire_y; fire_ack SHALL pulse in that next cycle.
REQ-018 On fire=1 with no FREE slot, state SHALL be unchanged and fire_drop SHALL pulse in the next cycle; fire_ack and fire_drop are never both 1.
REQ-019 On frame_tick=1, each LIVE slot with by>=SPEED SHALL set by=by-SPEED; each LIVE slot with by<SPEED SHALL go FREE (no wrap-around).
REQ-020 A slot allocated in a cycle with frame_tick=1 SHALL not move on that tick.
REQ-021 kill_valid=1 SHALL set slot kill_id FREE next edge, overriding a same-cycle tick; kill of a FREE slot or kill_id>=N_SLOTS SHALL be ignored.
REQ-022 A slot freed by kill or tick SHALL not be allocatable in the same cycle.
REQ-023 active[i] SHALL equal (slot i==LIVE), registered.
REQ-024 pixel_on/pixel_id SHALL be registered, 1-cycle latency from pix_x/pix_y: pixel_on=1 iff some LIVE slot has 0<=pix-b<SIZE on both axes with mask bit 1; pixel_id = lowest such index, 0 when pixel_on=0.
REQ-025 Window compare SHALL use XW+1/YW+1-bit subtraction so pix<b never matches.

Reset
REQ-026 rst_n=0 SHALL immediately (asynchronously) force all slots FREE, bx=by=0, fire_ack=fire_drop=0, active=0, pixel_on=0, pixel_id=0.
REQ-027 Reset mid-flight SHALL discard all bullets; a fire pending on the deasserting edge SHALL be ignored, first accepted fire on the following edge.

Structure
REQ-028 Package bullet_pkg SHALL hold slot-state encoding (FREE=0, LIVE=1) and the mask function for REQ-016.
REQ-029 Per-slot state/position/motion SHALL live in sub-module bullet_slot, instantiated N_SLOTS times; allocation priority and pixel OR/priority encode stay in bullet_engine.

Verification
REQ-030 Reset, fire=1 at (100,200) -> next cycle fire_ack=1, active=0001; pix (102,200) -> pixel_on=1 id 0 one cycle later; pix (100,200) -> 0.
REQ-031 Five fires on consecutive cycles, defaults -> acks on first four, active=1111, fifth gives fire_drop=1, state unchanged.
REQ-032 Slot at by=10, SPEED=4: ticks -> by 6, 2, then FREE on third tick; active bit clears.
REQ-033 Same cycle kill_id=0 and frame_tick with slot 0 LIVE -> slot 0 FREE, not moved; with fire also asserted, full slots -> fire_drop.
REQ-034 Slots 1 and 2 overlapping at pix -> pixel_id=1; fire+tick same cycle -> new slot at exact fire_y after tick.
REQ-035 rst_n low mid-flight with 3 LIVE slots -> active=0000 and pixel_on=0 before next clk edge.

Source files
------------

// File: rtl/bullet_pkg.sv
// Shared definitions for the bullet engine: slot state encoding and the
// round sprite mask used by every slot's pixel hit test.
package bullet_pkg;

    typedef enum logic {
        SLOT_FREE = 1'b0,
        SLOT_LIVE = 1'b1
    } slot_state_t;

    // Upper bound on SIZE*SIZE for the flattened mask table (SIZE <= 15).
    localparam int MASK_BITS = 256;

    // Mask bit at sprite offset (dx,dy): evaluated in doubled coordinates so
    // the sprite centre lands on an integer for both odd and even SIZE.
    function automatic logic mask_bit(input int dx, input int dy,
                                      input int size, input int r2);
        int sx;
        int sy;
        sx = 2 * dx - size + 1;
        sy = 2 * dy - size + 1;
        return ((sx * sx + sy * sy) <= r2);
    endfunction

    // Flattened mask, bit index dy*size+dx; only evaluated at elaboration.
    function automatic logic [MASK_BITS-1:0] mask_table(input int size, input int r2);
        logic [MASK_BITS-1:0] m;
        m = '0;
        for (int dy = 0; dy < size; dy++) begin
            for (int dx = 0; dx < size; dx++) begin
                m[dy * size + dx] = mask_bit(dx, dy, size, r2);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: FREE/LIVE state, position, upward motion per frame and
// a combinational hit test of the current raster pixel against the sprite.
module bullet_slot
    import bullet_pkg::*;
#(
    parameter int SIZE  = 6,
    parameter int R2    = 26,
    parameter int SPEED = 4,
    parameter int XW    = 10,
    parameter int YW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alloc,
    input  logic [XW-1:0] ax,
    input  logic [YW-1:0] ay,
    input  logic          tick,
    input  logic          kill,
    input  logic [XW-1:0] pix_x,
    input  logic [YW-1:0] pix_y,
    output logic          live,
    output logic          hit
);

    localparam logic [MASK_BITS-1:0] MASK    = mask_table(SIZE, R2);
    localparam logic [YW-1:0]        SPEED_Y = YW'(SPEED);
    localparam logic signed [XW:0]   SIZE_X  = (XW+1)'(SIZE);
    localparam logic signed [YW:0]   SIZE_Y  = (YW+1)'(SIZE);

    slot_state_t   state;
    logic [XW-1:0] bx;
    logic [YW-1:0] by;

    logic signed [XW:0] dx_p0;
    logic signed [YW:0] dy_p0;
    logic               in_win_p0;
    logic [7:0]         idx_p0;

    // Kill wins over motion; allocation only ever targets a slot that was
    // FREE at cycle start, so a freshly spawned bullet skips this tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SLOT_FREE;
            bx    <= '0;
            by    <= '0;
        end else if (state == SLOT_LIVE) begin
            if (kill) begin
                state <= SLOT_FREE;
            end else if (tick) begin
                if (by >= SPEED_Y) begin
                    by <= by - SPEED_Y;
                end else begin
                    state <= SLOT_FREE;
                end
            end
        end else if (alloc) begin
            state <= SLOT_LIVE;
            bx    <= ax;
            by    <= ay;
        end
    end

    assign live = (state == SLOT_LIVE);

    // Window test with one extra bit so a pixel left of / above the sprite
    // goes negative instead of wrapping into range, then the mask lookup.
    always_comb begin
        dx_p0     = $signed({1'b0, pix_x}) - $signed({1'b0, bx});
        dy_p0     = $signed({1'b0, pix_y}) - $signed({1'b0, by});
        in_win_p0 = !dx_p0[XW] && (dx_p0 < SIZE_X) &&
                    !dy_p0[YW] && (dy_p0 < SIZE_Y);
        idx_p0    = 8'(int'(dy_p0) * SIZE + int'(dx_p0));
        hit       = 1'b0;
        if (live && in_win_p0) begin
            hit = MASK[idx_p0];
        end
    end

endmodule

// File: rtl/bullet_engine.sv
// Bullet pool: lowest-free-slot allocation, kill decode, frame motion via
// the per-slot instances, and a registered pixel OR / priority encoder.
module bullet_engine
    import bullet_pkg::*;
#(
    parameter int N_SLOTS = 4,
    parameter int SIZE    = 6,
    parameter int R2      = 26,
    parameter int SPEED   = 4,
    parameter int XW      = 10,
    parameter int YW      = 10,
    localparam int IDW    = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fire,
    input  logic [XW-1:0]      fire_x,
    input  logic [YW-1:0]      fire_y,
    input  logic               frame_tick,
    input  logic               kill_valid,
    input  logic [IDW-1:0]     kill_id,
    input  logic [XW-1:0]      pix_x,
    input  logic [YW-1:0]      pix_y,
    output logic               fire_ack,
    output logic               fire_drop,
    output logic [N_SLOTS-1:0] active,
    output logic               pixel_on,
    output logic [IDW-1:0]     pixel_id
);

    logic [N_SLOTS-1:0] live_p0;
    logic [N_SLOTS-1:0] free_p0;
    logic [N_SLOTS-1:0] grant_p0;
    logic [N_SLOTS-1:0] kill_p0;
    logic [N_SLOTS-1:0] hit_p0;
    logic               any_free_p0;
    logic [IDW-1:0]     hit_id_p0;

    // Lowest set bit of the free vector picks the slot to spawn into.
    always_comb begin
        free_p0     = ~live_p0;
        grant_p0    = free_p0 & (~free_p0 + N_SLOTS'(1));
        any_free_p0 = |free_p0;
    end

    for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
        assign kill_p0[i] = kill_valid && (int'(kill_id) == i);

        bullet_slot #(
            .SIZE  (SIZE),
            .R2    (R2),
            .SPEED (SPEED),
            .XW    (XW),
            .YW    (YW)
        ) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .alloc (fire && grant_p0[i]),
            .ax    (fire_x),
            .ay    (fire_y),
            .tick  (frame_tick),
            .kill  (kill_p0[i]),
            .pix_x (pix_x),
            .pix_y (pix_y),
            .live  (live_p0[i]),
            .hit   (hit_p0[i])
        );
    end

    assign active = live_p0;

    // Lowest-index hitting slot wins the pixel.
    always_comb begin
        hit_id_p0 = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (hit_p0[i]) begin
                hit_id_p0 = IDW'(i);
            end
        end
    end

    // Registered fire result pulses and pixel outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fire_ack  <= 1'b0;
            fire_drop <= 1'b0;
            pixel_on  <= 1'b0;
            pixel_id  <= '0;
        end else begin
            fire_ack  <= fire && any_free_p0;
            fire_drop <= fire && !any_free_p0;
            pixel_on  <= |hit_p0;
            pixel_id  <= hit_id_p0;
        end
    end

endmodule

// File: tb/tb_bullet_engine.sv
// Directed bench for bullet_engine with default parameters.
module tb_bullet_engine;

    logic       clk;
    logic       rst_n;
    logic       fire;
    logic [9:0] fire_x;
    logic [9:0] fire_y;
    logic       frame_tick;
    logic       kill_valid;
    logic [1:0] kill_id;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       fire_ack;
    logic       fire_drop;
    logic [3:0] active;
    logic       pixel_on;
    logic [1:0] pixel_id;

    int checks;
    int failures;

    bullet_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fire       (fire),
        .fire_x     (fire_x),
        .fire_y     (fire_y),
        .frame_tick (frame_tick),
        .kill_valid (kill_valid),
        .kill_id    (kill_id),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .fire_ack   (fire_ack),
        .fire_drop  (fire_drop),
        .active     (active),
        .pixel_on   (pixel_on),
        .pixel_id   (pixel_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int x, input int y, input logic on, input int id, input string tag);
        pix_x = 10'(x);
        pix_y = 10'(y);
        step();
        chk({tag, "_on"}, 32'(pixel_on), 32'(on));
        chk({tag, "_id"}, 32'(pixel_id), 32'(id));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        fire = 1'b0; fire_x = '0; fire_y = '0;
        frame_tick = 1'b0; kill_valid = 1'b0; kill_id = '0;
        pix_x = '0; pix_y = '0;
        #2;
        chk("rst_active", 32'(active), 32'h0);
        chk("rst_ack", 32'(fire_ack), 32'h0);
        chk("rst_drop", 32'(fire_drop), 32'h0);
        chk("rst_pix_on", 32'(pixel_on), 32'h0);
        chk("rst_pix_id", 32'(pixel_id), 32'h0);
        // fire held while in reset must not spawn anything
        fire = 1'b1; fire_x = 10'd100; fire_y = 10'd200;
        step();
        chk("rst_fire_ack", 32'(fire_ack), 32'h0);
        chk("rst_fire_active", 32'(active), 32'h0);
        fire = 1'b0;
        #2 rst_n = 1'b1;
        step();

        // single spawn and sprite probe
        fire = 1'b1; fire_x = 10'd100; fire_y = 10'd200;
        step();
        fire = 1'b0;
        chk("spawn_ack", 32'(fire_ack), 32'h1);
        chk("spawn_drop", 32'(fire_drop), 32'h0);
        chk("spawn_active", 32'(active), 32'h1);
        step();
        chk("spawn_ack_pulse", 32'(fire_ack), 32'h0);
        pix(102, 200, 1'b1, 0, "pix_top");
        pix(100, 200, 1'b0, 0, "pix_corner");
        pix(99, 202, 1'b0, 0, "pix_left");
        pix(105, 202, 1'b1, 0, "pix_right_edge");
        pix(106, 202, 1'b0, 0, "pix_past_right");
        pix(101, 201, 1'b1, 0, "pix_row1");

        // reset between scenarios
        #2 rst_n = 1'b0;
        #1 chk("rst2_active", 32'(active), 32'h0);
        rst_n = 1'b1;
        step();

        // five consecutive fires into four slots
        fire = 1'b1; fire_x = 10'd0;   fire_y = 10'd10;  step();
        chk("f1_ack", 32'(fire_ack), 32'h1);
        chk("f1_active", 32'(active), 32'h1);
        fire_x = 10'd200; fire_y = 10'd300; step();
        chk("f2_ack", 32'(fire_ack), 32'h1);
        chk("f2_active", 32'(active), 32'h3);
        fire_x = 10'd202; fire_y = 10'd300; step();
        chk("f3_ack", 32'(fire_ack), 32'h1);
        chk("f3_active", 32'(active), 32'h7);
        fire_x = 10'd400; fire_y = 10'd400; step();
        chk("f4_ack", 32'(fire_ack), 32'h1);
        chk("f4_active", 32'(active), 32'hf);
        fire_x = 10'd600; fire_y = 10'd600; step();
        fire = 1'b0;
        chk("f5_ack", 32'(fire_ack), 32'h0);
        chk("f5_drop", 32'(fire_drop), 32'h1);
        chk("f5_active", 32'(active), 32'hf);
        pix(602, 600, 1'b0, 0, "f5_no_sprite");
        chk("f5_drop_pulse", 32'(fire_drop), 32'h0);

        // slot 0 at y=10 climbs by 4 per tick and frees on the third
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        chk("t1_active", 32'(active), 32'hf);
        pix(2, 6, 1'b1, 0, "t1_at6");
        pix(2, 5, 1'b0, 0, "t1_above");
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        chk("t2_active", 32'(active), 32'hf);
        pix(2, 2, 1'b1, 0, "t2_at2");
        pix(2, 1, 1'b0, 0, "t2_above");
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        chk("t3_active", 32'(active), 32'he);
        pix(2, 2, 1'b0, 0, "t3_gone");

        // slots 1 (200,288) and 2 (202,288) overlap
        pix(203, 290, 1'b1, 1, "ovl_both");
        pix(206, 290, 1'b1, 2, "ovl_slot2");
        pix(206, 288, 1'b0, 0, "ovl_mask0");

        // fire with a tick: new slot 0 lands at exactly fire_y
        fire = 1'b1; fire_x = 10'd50; fire_y = 10'd50; frame_tick = 1'b1;
        step();
        fire = 1'b0; frame_tick = 1'b0;
        chk("ft_ack", 32'(fire_ack), 32'h1);
        chk("ft_active", 32'(active), 32'hf);
        pix(52, 50, 1'b1, 0, "ft_at_fire_y");
        pix(52, 46, 1'b0, 0, "ft_not_moved");
        pix(203, 286, 1'b1, 1, "ft_others_moved");

        // kill + tick + fire with all slots full
        kill_valid = 1'b1; kill_id = 2'd0; frame_tick = 1'b1;
        fire = 1'b1; fire_x = 10'd500; fire_y = 10'd500;
        step();
        kill_valid = 1'b0; frame_tick = 1'b0; fire = 1'b0;
        chk("kt_drop", 32'(fire_drop), 32'h1);
        chk("kt_ack", 32'(fire_ack), 32'h0);
        chk("kt_active", 32'(active), 32'he);
        pix(52, 50, 1'b0, 0, "kt_slot0_gone");

        // killing a FREE slot is ignored and it can still be allocated
        kill_valid = 1'b1; kill_id = 2'd0;
        fire = 1'b1; fire_x = 10'd500; fire_y = 10'd500;
        step();
        kill_valid = 1'b0; fire = 1'b0;
        chk("kf_ack", 32'(fire_ack), 32'h1);
        chk("kf_active", 32'(active), 32'hf);

        kill_valid = 1'b1; kill_id = 2'd2; step(); kill_valid = 1'b0;
        chk("k2_active", 32'(active), 32'hb);
        pix(206, 282, 1'b0, 0, "k2_slot2_gone");

        // asynchronous reset with three live slots
        pix(503, 502, 1'b1, 0, "pre_rst_pix");
        #2 rst_n = 1'b0;
        #1;
        chk("arst_active", 32'(active), 32'h0);
        chk("arst_pix_on", 32'(pixel_on), 32'h0);
        chk("arst_pix_id", 32'(pixel_id), 32'h0);
        #1 rst_n = 1'b1;
        step();
        chk("post_rst_active", 32'(active), 32'h0);
        chk("post_rst_pix", 32'(pixel_on), 32'h0);
        fire = 1'b1; fire_x = 10'd10; fire_y = 10'd10; step(); fire = 1'b0;
        chk("post_rst_ack", 32'(fire_ack), 32'h1);
        chk("post_rst_spawn", 32'(active), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
